// File: rtl/bitty_pkg.sv
// Shared types for the bitty fetch path: sequencer state encoding and the
// default halt encoding, also used by the core-top and memory-loader benches.
package bitty_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEM_WAIT,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } fetch_state_t;

    localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/bitty_watchdog.sv
// Execution watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th enabled cycle is reached.
module bitty_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + 1'b1;
    end

    // Fires during the last allowed cycle so the FSM leaves EXEC right after it.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bitty_fetch_ctrl.sv
// Instruction sequencer for the bitty core: fetches from a synchronous imem,
// issues each word with a run pulse and advances the PC on the core's done.
module bitty_fetch_ctrl
    import bitty_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEFAULT,
    parameter int          TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              stop,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       d_instr,
    output logic              run,
    input  logic              done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              wd_err,
    output logic [15:0]       instr_count
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       count_q, count_d;
    logic              wd_err_q, wd_err_d;
    logic              stop_q, stop_d;
    logic              imem_rd_q, imem_rd_d;
    logic              run_q, run_d;
    logic              halted_q, halted_d;
    logic              wd_clear, wd_enable, wd_expired;

    bitty_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign busy = (state_q != S_IDLE) && (state_q != S_HALT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        count_d   = count_q;
        wd_err_d  = wd_err_q;
        stop_d    = stop_q | (busy & stop);
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d  = S_FETCH;
                    pc_d     = start_pc;
                    count_d  = '0;
                    wd_err_d = 1'b0;
                    stop_d   = 1'b0;
                end
            end
            S_FETCH:    state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (imem_data == HALT_INSTR) begin
                    state_d = S_HALT;
                end else begin
                    instr_d = imem_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_clear = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                wd_enable = 1'b1;
                // done wins over a watchdog expiry landing in the same cycle
                if (done) begin
                    count_d = count_q + 1'b1;
                    pc_d    = branch_taken ? branch_target : pc_q + 1'b1;
                    state_d = (stop_q || stop) ? S_IDLE : S_FETCH;
                end else if (wd_expired) begin
                    wd_err_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE)
            stop_d = 1'b0;
        imem_rd_d = (state_d == S_FETCH);
        run_d     = (state_d == S_ISSUE);
        halted_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            count_q   <= '0;
            wd_err_q  <= 1'b0;
            stop_q    <= 1'b0;
            imem_rd_q <= 1'b0;
            run_q     <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            count_q   <= count_d;
            wd_err_q  <= wd_err_d;
            stop_q    <= stop_d;
            imem_rd_q <= imem_rd_d;
            run_q     <= run_d;
            halted_q  <= halted_d;
        end
    end

    assign imem_rd     = imem_rd_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign d_instr     = instr_q;
    assign run         = run_q;
    assign halted      = halted_q;
    assign wd_err      = wd_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// Self-checking bench for bitty_fetch_ctrl: imem model, scripted core
// responses and a program-level reference model for randomized runs.
module tb_bitty_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic        stop = 1'b0;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = '0;
    logic [15:0] d_instr;
    logic        run;
    logic        done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [7:0]  pc;
    logic        busy, halted, wd_err;
    logic [15:0] instr_count;

    int checks = 0;
    int failures = 0;
    logic [15:0] mem [256];

    bitty_fetch_ctrl #(.ADDR_W(8), .HALT_INSTR(16'hFFFF), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stop(stop),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .d_instr(d_instr), .run(run), .done(done), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc(pc), .busy(busy), .halted(halted),
        .wd_err(wd_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

    // Pulse start; returns at the negedge of the first cycle after acceptance.
    task automatic do_start(input logic [7:0] spc);
        @(negedge clk);
        start = 1'b1; start_pc = spc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run(output bit ok, output int cyc);
        ok = 0; cyc = 0;
        while (cyc < 64 && !ok) begin
            @(negedge clk);
            cyc++;
            if (run) ok = 1;
        end
    endtask

    // Core response: done lat cycles after the observed run pulse.
    task automatic give_done(input int lat, input bit tk, input logic [7:0] tgt, input bit stp);
        repeat (lat) @(negedge clk);
        done = 1'b1; branch_taken = tk; branch_target = tgt; stop = stp;
        @(negedge clk);
        done = 1'b0; branch_taken = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_rd, run, busy, halted, wd_err} !== 5'b0 || pc !== 8'h0 ||
            d_instr !== 16'h0 || instr_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_state rd/run/busy/halt/wd=%b pc=%0h instr=%0h cnt=%0d want all zero",
                     {imem_rd, run, busy, halted, wd_err}, pc, d_instr, instr_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_straight;
        bit ok; int cyc;
        logic [15:0] a, b;
        a = 16'($urandom_range(0, 16'hFFFE));
        b = 16'($urandom_range(0, 16'hFFFE));
        mem[0] = a; mem[1] = b; mem[2] = 16'hFFFF;
        do_start(8'h00);
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin
            failures++; $display("FAIL first_fetch rd=%b addr=%0h want 1/00", imem_rd, imem_addr);
        end
        wait_run(ok, cyc);
        checks++;
        if (!ok || cyc != 2 || d_instr !== a) begin
            failures++; $display("FAIL first_issue ok=%0d cyc=%0d instr=%0h want 1/2/%0h", ok, cyc, d_instr, a);
        end
        give_done(2, 0, 8'h0, 0);
        wait_run(ok, cyc);
        checks++;
        if (!ok || cyc + 3 != 5 || d_instr !== b) begin
            failures++; $display("FAIL second_issue interval=%0d instr=%0h want 5/%0h", cyc + 3, d_instr, b);
        end
        give_done(2, 0, 8'h0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h02 || instr_count !== 16'd2) begin
            failures++; $display("FAIL straight_halt halted=%b busy=%b pc=%0h cnt=%0d want 1/0/02/2",
                                 halted, busy, pc, instr_count);
        end
    endtask

    task automatic test_branch;
        bit ok; int cyc;
        do_start(8'h00);
        wait_run(ok, cyc);
        give_done(1, 1, 8'h10, 0);
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 8'h10 || instr_count !== 16'd1) begin
            failures++; $display("FAIL branch_fetch rd=%b addr=%0h cnt=%0d want 1/10/1", imem_rd, imem_addr, instr_count);
        end
        wait_run(ok, cyc);
        checks++;
        if (!ok || d_instr !== mem[8'h10]) begin
            failures++; $display("FAIL branch_issue instr=%0h want %0h", d_instr, mem[8'h10]);
        end
        give_done(1, 0, 8'h0, 1);
    endtask

    task automatic test_wrap;
        bit ok; int cyc;
        do_start(8'hFF);
        wait_run(ok, cyc);
        checks++;
        if (!ok || d_instr !== mem[8'hFF] || pc !== 8'hFF) begin
            failures++; $display("FAIL wrap_issue instr=%0h pc=%0h want %0h/ff", d_instr, pc, mem[8'hFF]);
        end
        give_done(1, 0, 8'h0, 0);
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin
            failures++; $display("FAIL wrap_fetch rd=%b addr=%0h want 1/00", imem_rd, imem_addr);
        end
        wait_run(ok, cyc);
        give_done(1, 0, 8'h0, 1);
    endtask

    task automatic test_stop;
        bit ok; int cyc; int stray;
        // stop latched mid-EXEC, honoured at the later done
        do_start(8'h05);
        wait_run(ok, cyc);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        give_done(2, 0, 8'h0, 0);
        checks++;
        if (busy !== 1'b0 || pc !== 8'h06 || instr_count !== 16'd1 || imem_rd !== 1'b0) begin
            failures++; $display("FAIL stop_latched busy=%b pc=%0h cnt=%0d rd=%b want 0/06/1/0",
                                 busy, pc, instr_count, imem_rd);
        end
        // stop coincident with done
        do_start(8'h05);
        wait_run(ok, cyc);
        give_done(1, 0, 8'h0, 1);
        stray = 0;
        repeat (6) begin
            if (imem_rd !== 1'b0 || busy !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0 || pc !== 8'h06 || instr_count !== 16'd1) begin
            failures++; $display("FAIL stop_with_done stray=%0d pc=%0h cnt=%0d want 0/06/1", stray, pc, instr_count);
        end
    endtask

    // Program-level model: PC follows branch/fallthrough, stops at a halt word.
    task automatic test_random;
        bit ok; int cyc; int lat; bit tk; logic [7:0] tgt; logic [7:0] mpc; logic [15:0] mcnt;
        logic [7:0] hpos;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
            hpos = 8'($urandom);
            mem[hpos] = 16'hFFFF;
            mpc = 8'($urandom);
            if (mpc == hpos) mpc = mpc + 8'd1;
            mcnt = '0;
            do_start(mpc);
            for (int k = 0; k < 8; k++) begin
                if (mem[mpc] == 16'hFFFF) begin
                    repeat (2) @(negedge clk);
                    checks++;
                    if (halted !== 1'b1 || pc !== mpc || instr_count !== mcnt) begin
                        failures++; $display("FAIL rand_halt halted=%b pc=%0h cnt=%0d want 1/%0h/%0d",
                                             halted, pc, instr_count, mpc, mcnt);
                    end
                    break;
                end
                wait_run(ok, cyc);
                checks++;
                if (!ok || d_instr !== mem[mpc] || pc !== mpc) begin
                    failures++; $display("FAIL rand_issue instr=%0h pc=%0h want %0h/%0h", d_instr, pc, mem[mpc], mpc);
                end
                lat = $urandom_range(1, 4);
                tk = 1'($urandom);
                tgt = (k == 2) ? hpos : 8'($urandom);
                give_done(lat, tk, tgt, k == 7);
                mpc = tk ? tgt : mpc + 8'd1;
                mcnt++;
                checks++;
                if (pc !== mpc || instr_count !== mcnt || busy !== (k != 7)) begin
                    failures++; $display("FAIL rand_retire pc=%0h cnt=%0d busy=%b want %0h/%0d/%b",
                                         pc, instr_count, busy, mpc, mcnt, k != 7);
                end
            end
        end
    endtask

    task automatic test_watchdog;
        bit ok; int cyc;
        mem[8'h30] = 16'h1234;
        do_start(8'h30);
        wait_run(ok, cyc);
        repeat (16) @(negedge clk);
        checks++;
        if (halted !== 1'b0 || wd_err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL wd_early halted=%b wd=%b busy=%b want 0/0/1", halted, wd_err, busy);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || wd_err !== 1'b1 || pc !== 8'h30 || instr_count !== 16'd0) begin
            failures++; $display("FAIL wd_expire halted=%b wd=%b pc=%0h cnt=%0d want 1/1/30/0",
                                 halted, wd_err, pc, instr_count);
        end
        do_start(8'h30);
        checks++;
        if (wd_err !== 1'b0 || halted !== 1'b0 || imem_rd !== 1'b1) begin
            failures++; $display("FAIL wd_clear wd=%b halted=%b rd=%b want 0/0/1", wd_err, halted, imem_rd);
        end
        wait_run(ok, cyc);
        give_done(1, 0, 8'h0, 1);
    endtask

    task automatic test_reset_mid;
        bit ok; int cyc; int bad;
        mem[8'h20] = 16'h0abc;
        do_start(8'h20);
        wait_run(ok, cyc);
        @(negedge clk); start = 1'b1; start_pc = 8'h40;
        @(negedge clk); start = 1'b0;
        checks++;
        if (pc !== 8'h20 || busy !== 1'b1) begin
            failures++; $display("FAIL start_while_busy pc=%0h busy=%b want 20/1", pc, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({imem_rd, run, busy, halted, wd_err} !== 5'b0 || pc !== 8'h0 || imem_addr !== 8'h0 ||
            d_instr !== 16'h0 || instr_count !== 16'h0) begin
            failures++; $display("FAIL reset_mid rd/run/busy/halt/wd=%b pc=%0h instr=%0h cnt=%0d want all zero",
                                 {imem_rd, run, busy, halted, wd_err}, pc, d_instr, instr_count);
        end
        done = 1'b1; branch_taken = 1'b1; branch_target = 8'h77;
        @(negedge clk);
        done = 1'b0; branch_taken = 1'b0;
        bad = 0;
        repeat (4) begin
            if (imem_rd !== 1'b0 || busy !== 1'b0 || pc !== 8'h0 || instr_count !== 16'h0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL stray_done bad_cycles=%0d want 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        test_reset;
        test_straight;
        test_branch;
        test_wrap;
        test_stop;
        test_random;
        test_watchdog;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitty_fetch_ctrl.md
# bitty_fetch_ctrl

Instruction sequencer for the bitty core: owns the program counter, reads 16-bit instructions from a synchronous instruction memory, presents each one to the core on `d_instr` with a one-cycle `run` pulse, and waits for the core's `done` before advancing. It sits between the instruction ROM/RAM and the core top level, replacing the testbench-driven `run`/`d_instr` stimulus, and supports branching, halting, stop requests and an execution watchdog.

## Interface
- `ADDR_W`, 8: instruction memory address width; the PC wraps modulo 2^ADDR_W.
- `HALT_INSTR`, 16'hFFFF: encoding that halts sequencing; it is never issued to the core.
- `TIMEOUT`, 1024: maximum cycles spent waiting for `done` before a watchdog error.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse: begin execution at `start_pc`; honoured only in IDLE or HALT.
- `start_pc`  in  ADDR_W  initial PC, sampled when `start` is accepted.
- `stop`  in  1  request: finish the current instruction, then return to IDLE.
- `imem_rd`  out  1  instruction memory read strobe.
- `imem_addr`  out  ADDR_W  read address, equal to the PC.
- `imem_data`  in  16  read data, valid the cycle after `imem_rd`.
- `d_instr`  out  16  instruction to the core, held stable from ISSUE until `done`.
- `run`  out  1  one-cycle issue pulse to the core.
- `done`  in  1  core completion pulse.
- `branch_taken`  in  1  sampled with `done`: load the PC from `branch_target`.
- `branch_target`  in  ADDR_W  next PC when `branch_taken` is high.
- `pc`  out  ADDR_W  current PC.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `wd_err`  out  1  sticky watchdog error; cleared by `start` or `reset`.
- `instr_count`  out  16  number of instructions retired; wraps; cleared by `start`.

## Operation
- States: IDLE, FETCH, MEM_WAIT, ISSUE, EXEC, HALT.
- IDLE: on `start`, set PC = `start_pc`, clear `instr_count` and `wd_err`, go to FETCH.
- FETCH: drive `imem_rd` = 1 with `imem_addr` = PC, go to MEM_WAIT.
- MEM_WAIT: capture `imem_data`.
  - If it equals `HALT_INSTR`, go to HALT; the PC stays on the halt word.
  - Otherwise, load `d_instr` and go to ISSUE.
- ISSUE: `run` = 1 for exactly this cycle; clear the watchdog counter; go to EXEC.
- EXEC: wait for `done`. When it arrives:
  - Increment `instr_count`.
  - Set PC = `branch_target` if `branch_taken` is high, else PC + 1 (wraps from 2^ADDR_W−1 to 0).
  - Go to IDLE if a stop is pending, else go to FETCH.
- Stop pending: `stop` is latched when seen in any busy state and cleared on entering IDLE. A `stop` arriving in the same cycle as `done` counts as pending.
- Watchdog: in EXEC the counter increments every cycle. When it reaches `TIMEOUT` without `done`, set `wd_err`, go to HALT, and leave the PC unchanged.
- HALT: idle until `start`, which behaves exactly as `start` from IDLE.
- Ignored inputs:
  - `done` outside EXEC.
  - `branch_taken` without `done`.
  - `start` while busy.
- Reset mid-operation: return to IDLE immediately. The next cycle `run` = 0, and the core must be reset in the same cycle.
- Reset values:
  - State IDLE.
  - PC = 0, `imem_addr` = 0, `d_instr` = 0, `instr_count` = 0, watchdog counter = 0.
  - `imem_rd`, `run`, `busy`, `halted` and `wd_err` all 0.
  - Stop-pending flag = 0.

## Timing
- `start` at cycle 0 → FETCH at cycle 1 (`imem_rd` = 1) → MEM_WAIT at 2 → ISSUE at 3 (`run` = 1, `d_instr` valid) → EXEC from 4.
- `done` at cycle N (N ≥ 4) → FETCH at N+1 with the new PC; the next `run` pulse is at N+3.
- Minimum issue interval is 4 cycles, assuming the core can return `done` one cycle after `run`.
- `d_instr` changes only in MEM_WAIT and is stable throughout ISSUE and EXEC.
- `pc`, `instr_count`, `halted` and `wd_err` are registered; they update on the edge that ends the state causing the change.
- `busy` is a decode of the state register; there is no combinational path from `done` to `run`.

## Structure
- Shared package `bitty_pkg`: the state enum `fetch_state_t` and the default `HALT_INSTR` constant, reused by the core-top and memory-loader benches.
- One sub-module, `bitty_watchdog`: counter with `clear`, `enable`, `expired` and parameter `TIMEOUT`. All other logic lives in a single FSM module.

## Test plan
- **Straight-line program:** memory [0]=A, [1]=B, [2]=16'hFFFF; core returns `done` 2 cycles after `run`; `start` with `start_pc` = 0 → `d_instr` A then B with `run` pulses 5 cycles apart, `halted` = 1, `pc` = 2, `instr_count` = 2.
- **Branch:** `done` on instruction 0 with `branch_taken` = 1, `branch_target` = 8'h10 → next `imem_addr` = 8'h10.
- **Wrap:** `start_pc` = 8'hFF, no branch → next fetch at 8'h00.
- **Stop with done:** `stop` and `done` in the same cycle → PC advances, `instr_count` increments, IDLE, no further `imem_rd`.
- **Watchdog:** with `TIMEOUT` = 16 and `done` withheld → after 16 EXEC cycles `wd_err` = 1, `halted` = 1, PC unchanged; a following `start` clears `wd_err`.
- **Reset mid-EXEC, then ignored inputs:** `reset` during EXEC → the next cycle shows all outputs at their reset values and state IDLE. A stray `done` afterwards has no effect.
